// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, IF/ID flush, multi-cycle
// MUL/DIV sequencing and a saturating count of stalled cycles.
module pipe_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_load_use_i,
  input  logic        id_take_branch_i,
  input  logic        ex_mdu_start_i,
  input  logic        ex_mdu_is_div_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [4:0]  stall_o,
  output logic        flush_if_id_o,
  output logic        mdu_done_o,
  output logic [31:0] stall_cycles_o
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned SCNT_W  = 32;
  localparam logic [4:0]  ST_MEM  = 5'b01111;
  localparam logic [4:0]  ST_EX   = 5'b00111;
  localparam logic [4:0]  ST_ID   = 5'b00011;

  typedef enum logic {IDLE, MDU_BUSY} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SCNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic                mem_stall;
  logic [CNT_W-1:0]    n_cycles;

  assign mem_stall = mem_req_i & ~mem_ack_i;
  assign n_cycles  = ex_mdu_is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

  // Priority: reset > memory wait > MDU > load-use > branch flush.
  always_comb begin
    stall_o       = '0;
    flush_if_id_o = 1'b0;
    mdu_done_o    = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    if (!rst) begin
      if (mem_stall) begin
        stall_o = ST_MEM;
      end else if (state_q == MDU_BUSY && ex_mdu_start_i) begin
        stall_o = ST_EX;
        if (cnt_q == CNT_W'(1)) begin
          mdu_done_o = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (ex_mdu_start_i) begin
        stall_o = ST_EX;
        state_d = IDLE;
        if (n_cycles == CNT_W'(1)) begin
          mdu_done_o = 1'b1;
        end else begin
          cnt_d   = n_cycles - CNT_W'(1);
          state_d = MDU_BUSY;
        end
      end else begin
        // A busy MDU whose start dropped was flushed out of EX: abandon it.
        state_d = IDLE;
        if (id_load_use_i) begin
          stall_o = ST_ID;
        end
      end
      // A branch held in ID re-resolves once ID is released.
      flush_if_id_o = id_take_branch_i & ~stall_o[1];
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_o[0] && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_load_use, id_take_branch, ex_mdu_start, ex_mdu_is_div;
  logic        mem_req, mem_ack;
  logic [4:0]  stall, stall1;
  logic        flush, flush1, done, done1;
  logic [31:0] scyc, scyc1;

  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_load_use_i(id_load_use), .id_take_branch_i(id_take_branch),
    .ex_mdu_start_i(ex_mdu_start), .ex_mdu_is_div_i(ex_mdu_is_div),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .stall_o(stall), .flush_if_id_o(flush), .mdu_done_o(done),
    .stall_cycles_o(scyc)
  );

  pipe_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst),
    .id_load_use_i(id_load_use), .id_take_branch_i(id_take_branch),
    .ex_mdu_start_i(ex_mdu_start), .ex_mdu_is_div_i(ex_mdu_is_div),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .stall_o(stall1), .flush_if_id_o(flush1), .mdu_done_o(done1),
    .stall_cycles_o(scyc1)
  );

  typedef struct {
    logic [4:0]  stall;
    logic        flush;
    logic        done;
    bit          cchk;
    logic [31:0] cnt;
    bit          d1chk;
    logic [4:0]  d1stall;
    logic        d1done;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          nxt_cchk = 0;
  logic [31:0] nxt_cnt = '0;
  bit          nxt_d1chk = 0;
  logic [4:0]  nxt_d1stall = '0;
  logic        nxt_d1done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush_if_id", 32'(flush), 32'(e.flush));
      chk("mdu_done", 32'(done), 32'(e.done));
      if (e.cchk) chk("stall_cycles", scyc, e.cnt);
      if (e.d1chk) begin
        chk("mul1_stall", 32'(stall1), 32'(e.d1stall));
        chk("mul1_done", 32'(done1), 32'(e.d1done));
      end
    end
  end

  // Drive one cycle of inputs and queue the expected combinational response.
  task automatic cyc(input logic r, lu, br, st, dv, mr, ma,
                     input logic [4:0] es, input logic ef, ed);
    exp_t e;
    rst = r; id_load_use = lu; id_take_branch = br;
    ex_mdu_start = st; ex_mdu_is_div = dv; mem_req = mr; mem_ack = ma;
    e.stall = es; e.flush = ef; e.done = ed;
    e.cchk = nxt_cchk; e.cnt = nxt_cnt;
    e.d1chk = nxt_d1chk; e.d1stall = nxt_d1stall; e.d1done = nxt_d1done;
    nxt_cchk = 0; nxt_d1chk = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cnt(input logic [31:0] v);
    nxt_cchk = 1; nxt_cnt = v;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
  endtask

  initial begin
    rst = 1; id_load_use = 0; id_take_branch = 0; ex_mdu_start = 0;
    ex_mdu_is_div = 0; mem_req = 0; mem_ack = 0;
    @(posedge clk); #1;

    // Reset dominates every other input.
    cyc(1, 1, 1, 1, 1, 1, 0, 5'b00000, 0, 0);
    expect_cnt(32'd0);
    cyc(1, 1, 1, 1, 0, 1, 0, 5'b00000, 0, 0);

    // Divide: 32 stalled cycles, done only in the last.
    expect_cnt(32'd0);
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 1, 1, 0, 0, 5'b00111, 0, (i == 31));
    expect_cnt(32'd32);
    cyc(0, 0, 1, 0, 0, 0, 0, 5'b00000, 1, 0);
    do_reset();

    // Multiply interrupted by a 3-cycle memory wait.
    expect_cnt(32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 0, 1, 0, 5'b01111, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 1);
    expect_cnt(32'd5);
    cyc(0, 0, 0, 0, 0, 1, 1, 5'b00000, 0, 0);
    do_reset();

    // Load-use beats branch; branch flushes once ID is free.
    cyc(0, 1, 1, 0, 0, 0, 0, 5'b00011, 0, 0);
    expect_cnt(32'd1);
    cyc(0, 0, 1, 0, 0, 0, 0, 5'b00000, 1, 0);
    cyc(0, 1, 1, 0, 0, 1, 0, 5'b01111, 0, 0);
    do_reset();

    // Single-cycle multiply (dut1) versus two-cycle multiply (dut).
    nxt_d1chk = 1; nxt_d1stall = 5'b00111; nxt_d1done = 1;
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 0);
    nxt_d1chk = 1; nxt_d1stall = 5'b00111; nxt_d1done = 1;
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 1);
    nxt_d1chk = 1; nxt_d1stall = 5'b00000; nxt_d1done = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
    do_reset();

    // Reset in cycle 10 of a divide aborts it.
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 1, 1, 0, 0, 5'b00111, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 5'b00000, 0, 0);
    expect_cnt(32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);

    // Start dropping mid-divide aborts; a following multiply starts fresh.
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1, 1, 0, 0, 5'b00111, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 5'b00111, 0, 1);
    do_reset();

    // Counter saturates rather than wrapping.
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0);
    expect_cnt(32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
